// File: rtl/photon_binner.sv
// Photon binner: synchronises the detector pulse train, bins rising edges per
// sample period and sequences correlator clear / run / done for each measurement.
module photon_binner #(
  parameter int unsigned CLR_CYCLES = 512,
  parameter int unsigned PER_W      = 16,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             photon,
  input  logic             start,
  input  logic             stop,
  input  logic [PER_W-1:0] period,
  input  logic [CNT_W-1:0] nSamples,
  output logic [7:0]       corrData,
  output logic             corrSig,
  output logic             corrClr,
  output logic             busy,
  output logic             done,
  output logic [15:0]      satCnt
);

  localparam int unsigned CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam int unsigned BIN_W = 9;

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} stateE;

  stateE            state;
  stateE            stateNext;
  logic [2:0]       syncQ;
  logic             edgeEv;
  logic [PER_W-1:0] periodEff;
  logic [PER_W-1:0] perLat;
  logic [CNT_W-1:0] nLat;
  logic [PER_W-1:0] perCnt;
  logic [CNT_W-1:0] sampleCnt;
  logic [CLR_W-1:0] clrCnt;
  logic [BIN_W-1:0] bin;
  logic             binOvf;
  logic [BIN_W-1:0] binSum;
  logic             saturated;
  logic             loadRun;
  logic             terminal;
  logic             lastSample;

  // Periods below 2 would leave no room between strobes
  assign periodEff = (period < PER_W'(2)) ? PER_W'(2) : period;

  // Next-state and per-cycle control decisions
  always_comb begin
    stateNext  = state;
    loadRun    = 1'b0;
    terminal   = 1'b0;
    lastSample = 1'b0;
    binSum     = bin + BIN_W'(edgeEv);
    saturated  = binOvf | binSum[BIN_W-1];
    case (state)
      IDLE: begin
        if (start && !stop) begin
          stateNext = CLEAR;
          loadRun   = 1'b1;
        end
      end
      CLEAR: begin
        if (stop) begin
          stateNext = DONE;
        end else if (clrCnt == CLR_W'(CLR_CYCLES - 1)) begin
          stateNext = RUN;
        end
      end
      RUN: begin
        terminal   = (perCnt == perLat - PER_W'(1));
        lastSample = terminal && (nLat != '0) && (sampleCnt + CNT_W'(1) == nLat);
        if (stop || lastSample) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        if (start) begin
          stateNext = CLEAR;
          loadRun   = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Input synchroniser and rising-edge detector
  always_ff @(posedge clk) begin
    if (rst) begin
      syncQ  <= '0;
      edgeEv <= 1'b0;
    end else begin
      syncQ  <= {syncQ[1:0], photon};
      edgeEv <= syncQ[1] & ~syncQ[2];
    end
  end

  // Run control outputs and binning datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      corrData  <= '0;
      corrSig   <= 1'b0;
      corrClr   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      satCnt    <= '0;
      perLat    <= '0;
      nLat      <= '0;
      perCnt    <= '0;
      sampleCnt <= '0;
      clrCnt    <= '0;
      bin       <= '0;
      binOvf    <= 1'b0;
    end else begin
      corrSig <= 1'b0;
      corrClr <= (stateNext == CLEAR);
      busy    <= (stateNext == CLEAR) || (stateNext == RUN);
      done    <= (stateNext == DONE);

      if (loadRun) begin
        perLat    <= periodEff;
        nLat      <= nSamples;
        satCnt    <= '0;
        sampleCnt <= '0;
      end

      if (state == CLEAR) begin
        clrCnt <= clrCnt + CLR_W'(1);
      end else begin
        clrCnt <= '0;
      end

      // Outside RUN the bin is discarded so an abort never leaks a partial count
      if (state != RUN) begin
        perCnt <= '0;
        bin    <= '0;
        binOvf <= 1'b0;
      end else if (terminal) begin
        perCnt    <= '0;
        bin       <= '0;
        binOvf    <= 1'b0;
        corrData  <= saturated ? 8'hFF : binSum[7:0];
        corrSig   <= 1'b1;
        sampleCnt <= sampleCnt + CNT_W'(1);
        if (saturated && (satCnt != 16'hFFFF)) begin
          satCnt <= satCnt + 16'd1;
        end
      end else begin
        perCnt <= perCnt + PER_W'(1);
        if (binSum[BIN_W-1]) begin
          bin    <= BIN_W'(255);
          binOvf <= 1'b1;
        end else begin
          bin <= binSum;
        end
      end
    end
  end

endmodule
